drive_mode_ctrl: RTL and testbench

- Parametrised successor to the manual-driving controller of the simulated car. It debounces the raw driver switches and runs the power and drive-state machines.
- It tracks the forward/reverse gear, generates blinking turn indicators, and produces the 4-bit moving command that is packed into the UART frame sent to the simulator.
- It adds behaviour the current controller lacks: input debouncing, power-on hold time, stall detection with pulse, blink timing, and an optional odometer.

---
 rtl/drive_mode_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_drive_mode_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_mode_ctrl.sv
// drive_mode_ctrl: debounced manual-driving controller with power/drive FSM, gear latch,
// blinking turn indicators and stall pulse. Odometer is built only when DRIVE_ODOMETER_EN is defined.
module drive_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 200000,
  parameter int POWER_HOLD_CYCLES = 100000000,
  parameter int BLINK_HALF_CYCLES = 25000000,
  parameter int ODO_TICK_CYCLES   = 10000000,
  parameter int MILEAGE_W         = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 power_on,
  input  logic                 power_off,
  input  logic                 clutch,
  input  logic                 throttle,
  input  logic                 brake,
  input  logic                 reverse,
  input  logic                 left,
  input  logic                 right,
  output logic                 power_light,
  output logic [2:0]           state_light,
  output logic                 gear_reverse,
  output logic [3:0]           moving_cmd,
  output logic                 turn_left_light,
  output logic                 turn_right_light,
  output logic                 stall_pulse,
  output logic [MILEAGE_W-1:0] mileage
);
  localparam int N_IN   = 8;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (POWER_HOLD_CYCLES > 1) ? $clog2(POWER_HOLD_CYCLES) : 1;
  localparam int BLK_W  = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_OFF          = 3'b000,
    ST_NOT_STARTING = 3'b001,
    ST_STARTING     = 3'b010,
    ST_MOVING       = 3'b100
  } state_t;

  logic [N_IN-1:0] w_raw;
  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;
  logic [N_IN-1:0] w_filt;

  assign w_raw = {right, left, reverse, brake, throttle, clutch, power_off, power_on};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
      assign w_filt = r_sync2;
    end else begin : g_filt
      for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
        logic [DB_W-1:0] r_db_cnt;
        logic            r_level;
        // Counter measures how long the synchronised level has disagreed with the accepted one.
        always_ff @(posedge sys_clk) begin
          if (rst) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
          end else if (r_sync2[gi] == r_level) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db_cnt <= '0;
            r_level  <= r_sync2[gi];
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        assign w_filt[gi] = r_level;
      end
    end
  endgenerate

  logic w_pon, w_poff, w_clu, w_thr, w_brk, w_rev;
  assign {w_brk, w_thr, w_clu, w_poff, w_pon} = w_filt[4:0];
  assign w_rev = w_filt[5];

  state_t            r_state;
  logic              r_armed;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_gear;
  logic              r_stall_pulse;
  logic              w_on;
  logic              w_stall;
  logic              w_go_off;

  assign w_on    = (r_state != ST_OFF);
  assign w_stall = ((r_state == ST_NOT_STARTING) && w_thr && !w_clu) ||
                   ((r_state == ST_MOVING) && !w_brk && !w_clu && (w_rev != r_gear));
  assign w_go_off = w_on && (w_poff || w_stall);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state       <= ST_OFF;
      r_armed       <= 1'b0;
      r_hold_cnt    <= '0;
      r_gear        <= 1'b0;
      r_stall_pulse <= 1'b0;
    end else begin
      r_stall_pulse <= 1'b0;
      if (w_go_off) begin
        r_state       <= ST_OFF;
        r_armed       <= 1'b0;
        r_hold_cnt    <= '0;
        r_stall_pulse <= !w_poff;
      end else begin
        case (r_state)
          ST_OFF: begin
            // Arming requires a released button so a held button cannot re-power after a stall.
            if (!w_pon) begin
              r_armed    <= 1'b1;
              r_hold_cnt <= '0;
            end else if (r_armed) begin
              if (r_hold_cnt == HOLD_W'(POWER_HOLD_CYCLES - 1)) begin
                r_state    <= ST_NOT_STARTING;
                r_gear     <= w_rev;
                r_armed    <= 1'b0;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
          end
          ST_NOT_STARTING: begin
            if (w_thr) r_state <= ST_STARTING;
            else       r_gear  <= w_rev;
          end
          ST_STARTING: begin
            if (w_brk)                r_state <= ST_NOT_STARTING;
            else if (w_thr && !w_clu) r_state <= ST_MOVING;
            else                      r_gear  <= w_rev;
          end
          ST_MOVING: begin
            if (w_brk)                  r_state <= ST_NOT_STARTING;
            else if (w_clu || !w_thr)   r_state <= ST_STARTING;
          end
          default: r_state <= ST_OFF;
        endcase
      end
    end
  end

  logic [1:0]       r_lr;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_on;

  assign w_sel = w_on ? w_filt[7:6] : 2'b00;

  // Any change of the selected side set restarts the blink phase in the on half.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_lr        <= 2'b00;
      r_sel       <= 2'b00;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
    end else begin
      r_lr  <= w_filt[7:6];
      r_sel <= w_sel;
      if (w_sel != r_sel) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == BLK_W'(BLINK_HALF_CYCLES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= !r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    moving_cmd = 4'b0000;
    if (r_state == ST_MOVING)
      moving_cmd = {((r_lr == 2'b11) ? 2'b00 : r_lr), r_gear, !r_gear};
  end

  assign power_light      = w_on;
  assign state_light      = r_state;
  assign gear_reverse     = r_gear;
  assign stall_pulse      = r_stall_pulse;
  assign turn_left_light  = w_on && r_blink_on && r_sel[0];
  assign turn_right_light = w_on && r_blink_on && r_sel[1];

`ifdef DRIVE_ODOMETER_EN
  localparam int ODO_W = (ODO_TICK_CYCLES > 1) ? $clog2(ODO_TICK_CYCLES) : 1;
  logic [ODO_W-1:0]     r_odo_tick;
  logic [MILEAGE_W-1:0] r_mileage;

  always_ff @(posedge sys_clk) begin
    if (rst || w_go_off) begin
      r_odo_tick <= '0;
      r_mileage  <= '0;
    end else if (r_state == ST_MOVING) begin
      if (r_odo_tick == ODO_W'(ODO_TICK_CYCLES - 1)) begin
        r_odo_tick <= '0;
        if (r_mileage != '1) r_mileage <= r_mileage + 1'b1;
      end else begin
        r_odo_tick <= r_odo_tick + 1'b1;
      end
    end
  end
  assign mileage = r_mileage;
`else
  assign mileage = '0;
`endif

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// tb_drive_mode_ctrl: directed test-plan steps followed by random switch activity, every cycle
// compared against a behavioural model built from filter windows, elapsed-time and cycle counts.
module tb_drive_mode_ctrl;
  localparam int D  = 2;
  localparam int P  = 4;
  localparam int BH = 3;
  localparam int T  = 5;
  localparam int MW = 16;
`ifdef DRIVE_ODOMETER_EN
  localparam int ODO_ON = 1;
`else
  localparam int ODO_ON = 0;
`endif
  localparam int S_OFF = 0, S_NS = 1, S_ST = 2, S_MV = 4;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic power_on = 0, power_off = 0, clutch = 0, throttle = 0;
  logic brake = 0, reverse = 0, left = 0, right = 0;
  logic          power_light, gear_reverse, turn_left_light, turn_right_light, stall_pulse;
  logic [2:0]    state_light;
  logic [3:0]    moving_cmd;
  logic [MW-1:0] mileage;

  drive_mode_ctrl #(
    .DEBOUNCE_CYCLES(D), .POWER_HOLD_CYCLES(P), .BLINK_HALF_CYCLES(BH),
    .ODO_TICK_CYCLES(T), .MILEAGE_W(MW)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .power_on(power_on), .power_off(power_off),
    .clutch(clutch), .throttle(throttle), .brake(brake), .reverse(reverse),
    .left(left), .right(right), .power_light(power_light), .state_light(state_light),
    .gear_reverse(gear_reverse), .moving_cmd(moving_cmd), .turn_left_light(turn_left_light),
    .turn_right_light(turn_right_light), .stall_pulse(stall_pulse), .mileage(mileage)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: filtered level = value held by the last D synchronised samples.
  logic [7:0] hist [0:8191];
  int         n;
  logic [7:0] m_f;
  int         m_state, m_run, m_age, m_moves;
  bit         m_armed, m_gear, m_stall;
  logic [1:0] m_lr, m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_f = '0; m_state = S_OFF; m_run = 0; m_age = 0; m_moves = 0;
    m_armed = 0; m_gear = 0; m_stall = 0; m_lr = '0; m_sel = '0;
  endtask

  task automatic go_off(input bit is_stall);
    m_state = S_OFF; m_armed = 0; m_run = 0; m_stall = is_stall;
  endtask

  task automatic model_edge();
    logic [7:0] fs, fn, h;
    logic [1:0] sel;
    int  ps;
    bit  on_b, flip, pon, poff, clu, thr, brk, rev;
    hist[n] = {right, left, reverse, brake, throttle, clutch, power_off, power_on};
    fs = m_f; ps = m_state; on_b = (ps != S_OFF);
    pon = fs[0]; poff = fs[1]; clu = fs[2]; thr = fs[3]; brk = fs[4]; rev = fs[5];
    m_stall = 0;
    if (on_b && poff) go_off(0);
    else case (ps)
      S_OFF: begin
        if (!pon) begin m_armed = 1; m_run = 0; end
        else if (m_armed) begin
          m_run++;
          if (m_run == P) begin m_state = S_NS; m_gear = rev; m_armed = 0; m_run = 0; end
        end
      end
      S_NS: if (thr && !clu) go_off(1); else if (thr && clu) m_state = S_ST; else m_gear = rev;
      S_ST: if (brk) m_state = S_NS; else if (thr && !clu) m_state = S_MV; else m_gear = rev;
      S_MV: begin
        if (brk) m_state = S_NS;
        else if (clu) m_state = S_ST;
        else if (rev != m_gear) go_off(1);
        else if (!thr) m_state = S_ST;
      end
      default: ;
    endcase
    if (on_b && m_state == S_OFF) m_moves = 0;
    else if (ps == S_MV) m_moves++;
    m_lr = fs[7:6];
    sel = on_b ? fs[7:6] : 2'b00;
    if (sel != m_sel) begin m_sel = sel; m_age = 0; end
    else m_age++;
    fn = m_f;
    for (int b = 0; b < 8; b++) begin
      flip = 1;
      for (int k = n - 1 - D; k <= n - 2; k++) begin
        h = (k >= 0) ? hist[k] : 8'h00;
        if (h[b] == m_f[b]) flip = 0;
      end
      if (flip) fn[b] = !m_f[b];
    end
    m_f = fn;
    n++;
  endtask

  function automatic logic [31:0] dut_vec();
    return {4'b0, state_light, power_light, gear_reverse, moving_cmd,
            turn_left_light, turn_right_light, stall_pulse, mileage};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [3:0]    cmd;
    logic [MW-1:0] mil;
    bit            blink;
    int            mi;
    cmd = 4'b0000;
    if (m_state == S_MV) cmd = {((m_lr == 2'b11) ? 2'b00 : m_lr), m_gear, !m_gear};
    blink = (m_state != S_OFF) && ((m_age / BH) % 2 == 0);
    mi  = m_moves / T;
    mil = (ODO_ON != 0) ? ((mi > 65535) ? 16'hFFFF : MW'(mi)) : '0;
    return {4'b0, 3'(m_state), m_state != S_OFF, m_gear, cmd,
            blink && m_sel[0], blink && m_sel[1], m_stall, mil};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    if (!rst) model_edge();
    @(negedge sys_clk);
    if (!rst) chk("outputs", dut_vec(), exp_vec());
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  initial begin
    model_reset();
    run(3);
    chk("reset_outputs", dut_vec(), 32'h0);
    rst = 1'b0;

    // 1. power-up hold
    run(10);
    power_on = 1; run(3); power_on = 0; run(8);
    chk("short_hold_state", state_light, 3'b000);
    power_on = 1; run(7);
    chk("hold_minus1_state", state_light, 3'b000);
    run(1);
    chk("hold_state", state_light, 3'b001);
    chk("hold_power_light", power_light, 1'b1);
    run(10);
    chk("rehold_state", state_light, 3'b001);
    power_on = 0; run(6);

    // 2. drive path
    clutch = 1; throttle = 1; run(5);
    chk("starting_state", state_light, 3'b010);
    clutch = 0; run(5);
    chk("moving_state", state_light, 3'b100);
    chk("moving_cmd_fwd", moving_cmd, 4'b0001);
    brake = 1; throttle = 0; run(5);
    chk("brake_state", state_light, 3'b001);
    chk("brake_cmd", moving_cmd, 4'b0000);
    brake = 0; run(5);

    // 3. stall in NOT_STARTING, held power_on must not restart
    power_on = 1; run(6);
    throttle = 1; run(4);
    chk("pre_stall_state", state_light, 3'b001);
    tick();
    chk("stall_state", state_light, 3'b000);
    chk("stall_pulse_hi", stall_pulse, 1'b1);
    tick();
    chk("stall_pulse_lo", stall_pulse, 1'b0);
    throttle = 0; run(12);
    chk("held_no_restart", state_light, 3'b000);
    power_on = 0; run(6);
    power_on = 1; run(8);
    chk("restart_state", state_light, 3'b001);
    power_on = 0; run(5);

    // 4. reverse gear
    clutch = 1; throttle = 1; run(5);
    reverse = 1; run(5);
    chk("gear_follows", gear_reverse, 1'b1);
    clutch = 0; run(5);
    chk("reverse_cmd", moving_cmd, 4'b0010);
    reverse = 0; run(4); tick();
    chk("rev_stall_state", state_light, 3'b000);
    chk("rev_stall_pulse", stall_pulse, 1'b1);
    throttle = 0; power_on = 1; run(8);
    power_on = 0;
    clutch = 1; throttle = 1; run(5);
    clutch = 0; run(5);
    chk("moving_again", state_light, 3'b100);
    reverse = 1; clutch = 1; run(4); tick();
    chk("rev_clutch_state", state_light, 3'b010);
    chk("rev_clutch_nostall", stall_pulse, 1'b0);
    run(1);

    // 5. turn lights
    reverse = 0; run(5);
    clutch = 0; run(5);
    left = 1; run(4); tick();
    chk("left_cmd", moving_cmd, 4'b0101);
    chk("left_blink_0", turn_left_light, 1'b1);
    for (int i = 1; i < 9; i++) begin
      tick();
      chk("left_blink", turn_left_light, ((i / 3) % 2 == 0) ? 1'b1 : 1'b0);
    end
    right = 1; run(4); tick();
    chk("both_cmd", moving_cmd, 4'b0001);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("both_blink", {turn_left_light, turn_right_light},
          ((i / 3) % 2 == 0) ? 2'b11 : 2'b00);
    end
    power_off = 1; run(5);
    chk("poff_lights", {turn_left_light, turn_right_light}, 2'b00);
    chk("poff_state", state_light, 3'b000);

    // 6. odometer
    power_off = 0; left = 0; right = 0; throttle = 0; run(6);
    power_on = 1; run(8); power_on = 0;
    clutch = 1; throttle = 1; run(5);
    clutch = 0; run(5);
    run(7);
    clutch = 1; run(5);
    chk("odo_state", state_light, 3'b010);
    chk("odo_12", mileage, (ODO_ON != 0) ? 32'd2 : 32'd0);
    run(7);
    chk("odo_hold", mileage, (ODO_ON != 0) ? 32'd2 : 32'd0);
    power_off = 1; run(5);
    chk("odo_clear", mileage, 32'd0);
    power_off = 0; clutch = 0; throttle = 0; run(6);

    // random switch activity, including sub-debounce glitches
    for (int i = 0; i < 300; i++) begin
      power_on  = ($urandom_range(0, 99) < 35);
      power_off = ($urandom_range(0, 99) < 4);
      clutch    = 1'($urandom_range(0, 1));
      throttle  = 1'($urandom_range(0, 1));
      brake     = ($urandom_range(0, 99) < 20);
      reverse   = ($urandom_range(0, 99) < 30);
      left      = 1'($urandom_range(0, 1));
      right     = 1'($urandom_range(0, 1));
      run($urandom_range(1, 9));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
